// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART FSM state encoding and parity-type constants shared by RX and TX
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - RX line synchronizer, start-edge detect, bit-period counter and bit sampler
// UART_RX_MAJORITY_EN selects 2-of-3 majority sampling; default is a single mid-bit sample.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic idle,
  output logic start_det,
  output logic sample_bit,
  output logic bit_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] cnt;

  // Flops reset to 0 so a line already low at reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
      if (start_det)
        cnt <= CW'(1);
      else if (!idle)
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  assign start_det = idle & prev & ~sync2;
  assign bit_done  = ~idle & (cnt == CNT_DEC);

`ifdef UART_RX_MAJORITY_EN
  logic samp_a;
  logic samp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else begin
      if (cnt == CNT_MID - 1'b1)
        samp_a <= sync2;
      if (cnt == CNT_MID)
        samp_b <= sync2;
    end
  end

  // Third vote is the live sample at the decision count.
  assign sample_bit = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
`else
  logic samp_mid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      samp_mid <= 1'b0;
    else if (cnt == CNT_MID)
      samp_mid <= sync2;
  end

  assign sample_bit = samp_mid;
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver top: frame FSM, shift register, parity/stop checks, output strobes
// Sampling mode is chosen by UART_RX_MAJORITY_EN inside uart_rx_sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR,
  output logic             Busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  uart_state_e      state;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             par_en_l;
  logic             par_typ_l;
  logic             par_ok;
  logic             start_det;
  logic             sample_bit;
  logic             bit_done;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk       (CLK),
    .rst_n     (RST),
    .rx        (RX_IN),
    .idle      (state == IDLE),
    .start_det (start_det),
    .sample_bit(sample_bit),
    .bit_done  (bit_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      par_ok     <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            state     <= START;
            Busy      <= 1'b1;
            bit_cnt   <= '0;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            par_ok    <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            if (sample_bit) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= {sample_bit, shift_reg[WIDTH-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT)
              state <= par_en_l ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_done) begin
            par_ok <= (sample_bit == ((^shift_reg) ^ (par_typ_l == PAR_ODD)));
            state  <= STOP;
          end
        end
        STOP: begin
          // Leaving at the stop-bit decision point leaves half a bit of slack for the next start.
          if (bit_done) begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (par_ok && sample_bit) begin
              DATA_VALID <= 1'b1;
              P_DATA     <= shift_reg;
            end else begin
              PAR_ERR <= ~par_ok;
              STP_ERR <= ~sample_bit;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx (WIDTH=8, OVERSAMPLE=8)
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       Busy;

  uart_rx #(.WIDTH(8), .OVERSAMPLE(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .Busy      (Busy)
  );

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every strobe cycle pops the oldest expected frame outcome.
  always @(negedge CLK) begin
    if (RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_valid", DATA_VALID, e.dv);
        chk("par_err", PAR_ERR, e.pe);
        chk("stp_err", STP_ERR, e.se);
        chk("p_data", P_DATA, e.pd);
        chk("strobe_cycle", cyc, e.due);
        chk("busy_at_strobe", Busy, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle_line(input int n);
    RX_IN = 1'b1;
    tick(n);
  endtask

  task automatic wait_neg(input int c);
    @(negedge CLK);
    while (cyc < c) @(negedge CLK);
  endtask

  // Called at #1 after a rising edge; drives one full frame, pin-cycle 0 = start bit.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic flip, input logic stp, input int spike_idx);
    logic bits[$];
    logic par_bit;
    logic par_ok;
    exp_t e;
    int   t0;
    PAR_EN  = pe;
    PAR_TYP = pt;
    t0 = cyc;
    par_bit = (^d) ^ pt ^ flip;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(par_bit);
    bits.push_back(stp);
    par_ok = !pe || (par_bit == ((^d) ^ pt));
    if (par_ok && stp) last_good = d;
    e.dv  = par_ok && stp;
    e.pe  = !par_ok;
    e.se  = !stp;
    e.pd  = last_good;
    e.due = t0 + (pe ? 88 : 80);
    sb.push_back(e);
    for (int i = 0; i < bits.size(); i++) begin
      RX_IN = bits[i];
      if (i == 4) begin
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
      end
      if (i == spike_idx) begin
        tick(4);
        RX_IN = ~bits[i];
        tick(1);
        RX_IN = bits[i];
        tick(3);
      end else begin
        tick(8);
      end
    end
  endtask

  initial begin
    int t0;
    RST     = 1'b0;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    tick(4);
    chk("reset_p_data", P_DATA, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_strobes", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
    RST = 1'b1;
    idle_line(10);

    send_frame(8'h69, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h69, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h69, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h69, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idle_line(3);
    send_frame(8'h69, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hB6, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle_line(5);

    // Short low glitch: Busy must pulse and no strobe may follow.
    t0 = cyc;
    RX_IN = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    wait_neg(t0 + 2);
    chk("glitch_busy_before", Busy, 0);
    wait_neg(t0 + 3);
    chk("glitch_busy_high", Busy, 1);
    wait_neg(t0 + 9);
    chk("glitch_busy_low", Busy, 0);
    @(posedge CLK);
    #1;
    idle_line(10);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 7);
    idle_line(3);
`endif

    // Reset in the middle of data bit 3.
    RX_IN = 1'b0;
    tick(8);
    RX_IN = 1'b1;
    tick(8);
    RX_IN = 1'b0;
    tick(8);
    RX_IN = 1'b1;
    tick(11);
    chk("busy_mid_frame", Busy, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("async_reset_p_data", P_DATA, 0);
    chk("async_reset_busy", Busy, 0);
    chk("async_reset_strobes", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
    last_good = 8'h00;
    tick(3);
    RST = 1'b1;
    idle_line(6);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle_line(4);

    // Line held low through reset release must not start a frame.
    RX_IN = 1'b0;
    #2;
    RST = 1'b0;
    tick(4);
    RST = 1'b1;
    tick(30);
    chk("low_through_reset_busy", Busy, 0);
    idle_line(20);
    chk("low_through_reset_busy_after", Busy, 0);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic       fl;
      logic       st;
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      fl = pe && ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, pe, pt, fl, st, -1);
      if (!st) idle_line(2 + $urandom_range(0, 4));
      else idle_line($urandom_range(0, 5));
    end

    for (int w = 0; w < 300 && sb.size() != 0; w++) tick(1);
    if (sb.size() != 0) chk("missing_strobes", sb.size(), 0);
    idle_line(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: oversamples a UART line, recovers start/data/optional parity/stop fields and presents the received byte as a parallel word with a one-cycle valid strobe and error flags. It is the receive half of the UART link, with the same frame format, parity polarity and parallel-side naming as the team's UART transmitter. It sits between the board-level RX pin and the system register/FIFO logic.

## Interface
- `WIDTH`, 8: data bits per frame.
- `OVERSAMPLE`, 8: clocks per bit period; even, ≥ 6.
- `CLK` in 1: receiver clock, OVERSAMPLE × baud.
- `RST` in 1: asynchronous, active-low reset.
- `RX_IN` in 1: serial line, idle high, asynchronous to CLK.
- `PAR_EN` in 1: 1 = frame carries a parity bit.
- `PAR_TYP` in 1: 0 = even parity, 1 = odd parity.
- `P_DATA` out WIDTH: last good received word, LSB = first data bit.
- `DATA_VALID` out 1: one-cycle strobe; P_DATA updated this cycle.
- `PAR_ERR` out 1: one-cycle strobe; parity mismatch on the frame just ended.
- `STP_ERR` out 1: one-cycle strobe; stop bit sampled 0.
- `Busy` out 1: high while a frame is in progress (FSM not IDLE).

## Operation
- RX_IN passes through a 2-flop synchronizer. Synchronizer flops and the edge-detect register reset to 0, so a line held low through reset is never taken as a start bit; a high-to-low transition is required.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START on a synchronized falling edge; the edge counter is cleared to 0 in that cycle, the bit counter is cleared, and PAR_EN/PAR_TYP are latched for the whole frame.
- The edge counter runs 0..OVERSAMPLE-1 per bit and then wraps; the bit value is decided at count OVERSAMPLE/2+1.
- START: decided value 1 → glitch, return to IDLE with no strobes. Decided value 0 → DATA at the wrap.
- DATA: shift WIDTH bits LSB-first into the shift register. After the last bit, go to PARITY if PAR_EN is latched, else STOP.
- PARITY: expected bit = XOR(data) ^ PAR_TYP.
- STOP: at the decision point, return to IDLE immediately (this gives half-bit slack for back-to-back frames). The next cycle registers the strobes:
  - DATA_VALID=1 and P_DATA ← shift register only if parity is OK (or disabled) and stop = 1.
  - Otherwise P_DATA is unchanged and PAR_ERR and/or STP_ERR = 1. Both may assert together.
- Reset values: P_DATA=0; DATA_VALID, PAR_ERR, STP_ERR, Busy = 0; FSM = IDLE; all counters = 0.
- Reset asserted mid-frame: the frame is abandoned, no strobe is generated, and all outputs return to reset values asynchronously.
- PAR_EN/PAR_TYP changes mid-frame have no effect until the next start detection.

## Timing
- Synchronized falling edge to DATA_VALID: (N-1)·OVERSAMPLE + OVERSAMPLE/2 + 2 cycles, with N = 10 (no parity) or 11 (parity). Add 2 cycles from the RX_IN pin.
- Example, OVERSAMPLE=8: 80 cycles from the pin (no parity), 88 cycles (parity).
- Busy rises in the cycle after edge detection and falls in the cycle DATA_VALID/error strobes are asserted.
- A new falling edge is accepted in the cycle after STOP → IDLE.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of synchronized samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- Undefined: single sample at count OVERSAMPLE/2.
- Decision point and all latencies are identical in both builds.

## Structure
- Shared package `uart_pkg`: FSM state enum (IDLE, START, DATA, PARITY, STOP) and parity-type constants (PAR_EVEN=0, PAR_ODD=1), shared with the transmitter.
- Sub-module `uart_rx_sampler`: synchronizer, edge detect, edge counter and sample/majority logic. It outputs `sample_bit` and a one-cycle `bit_done` pulse.
- The top level holds the FSM, bit counter, shift register, parity/stop checks and output registers.

## Test plan
All scenarios use OVERSAMPLE=8.
- No parity, frame 0x69 → DATA_VALID for 1 cycle exactly 80 cycles after the pin edge, P_DATA=0x69, no error strobes.
- Even parity, 0x69 with parity bit 0 → DATA_VALID, P_DATA=0x69. Same frame with parity bit 1 → PAR_ERR=1, DATA_VALID=0, P_DATA keeps 0x69.
- Odd parity, 0x69 with parity bit 1 → DATA_VALID. Stop bit forced to 0 → STP_ERR=1, no DATA_VALID.
- Back-to-back frames 0x69 then 0xB6 with no idle gap → two DATA_VALID strobes 80 cycles apart carrying the correct bytes.
- 2-cycle low glitch on an idle line → FSM returns to IDLE, no strobes, Busy pulses. With the macro defined, a 1-cycle inverted spike at count 4 of a data bit → byte still correct.
- RST asserted at data bit 3 → outputs 0 immediately. A frame sent after release is received correctly. RX_IN held low across reset release → no frame detected.
